instr_mem_loader: RTL and testbench

//  Write-side counterpart of the instruction memory. Receives a program image as a

---
 rtl/instr_mem_loader.sv | 164 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: packs big-endian bytes into 32-bit words and writes them into the IM.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int unsigned ADDR_W    = 5,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);
    localparam int unsigned CW    = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StLoad,
`ifdef LOADER_CHECKSUM_EN
        StChk,
`endif
        StDone,
        StErr
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   word_q, word_d;
    logic [1:0]      byte_q, byte_d;
    logic [23:0]     shift_q, shift_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      chk_q, chk_d;
`endif
    logic            accept;

    assign accept = rx_valid & rx_ready;

    // All bytes of the image accepted once word_q reaches count_q; stop taking bytes then.
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            StHdr:  rx_ready = 1'b1;
            StLoad: rx_ready = (word_q != count_q);
`ifdef LOADER_CHECKSUM_EN
            StChk:  rx_ready = 1'b1;
`endif
            default: rx_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        word_d  = word_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        if (start) begin
            // A restart discards any byte handshaken in the same cycle.
            state_d = StHdr;
            count_d = '0;
            word_d  = '0;
            byte_d  = '0;
            shift_d = '0;
`ifdef LOADER_CHECKSUM_EN
            chk_d   = '0;
`endif
        end else begin
            case (state_q)
                StHdr: begin
                    if (accept) begin
                        if (rx_data == 8'd0 || 32'(rx_data) > DEPTH) begin
                            state_d = StErr;
                        end else begin
                            count_d = CW'(rx_data);
                            state_d = StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (word_q == count_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StDone;
`endif
                    end else if (accept) begin
                        shift_d = {shift_q[15:0], rx_data};
                        byte_d  = byte_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        chk_d   = chk_q ^ rx_data;
`endif
                        if (byte_q == 2'd3) begin
                            we_d    = 1'b1;
                            wdata_d = {shift_q, rx_data};
                            addr_d  = BASE_ADDR + (32'(word_q) << 2);
                            word_d  = word_q + CW'(1);
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                StChk: begin
                    if (accept) begin
                        state_d = (rx_data == chk_q) ? StDone : StErr;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            word_q  <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign im_we    = we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign done     = (state_q == StDone);
    assign err      = (state_q == StErr);
    assign cpu_hold = (state_q != StDone);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: header table, back-to-back and gapped images, restart, reset.
module tb_instr_mem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    instr_mem_loader #(
        .ADDR_W    (5),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] img[$];

    always @(negedge clk) begin
        if (im_we) begin
            wa.push_back(im_addr);
            wd.push_back(im_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] gen_word(input int s, input int k);
        return {s[7:0], k[7:0], s[7:0] ^ k[7:0] ^ 8'hC3, 8'h5A};
    endfunction

    function automatic logic [7:0] xor_img();
        logic [7:0] x = 8'h00;
        logic [31:0] w;
        for (int i = 0; i < img.size(); i++) begin
            w = img[i];
            x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        return x;
    endfunction

    // All drive tasks start and end just after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        while (!rx_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            tests++;
            fails++;
            $display("FAIL send_byte timeout: rx_ready=%0b, required 1", rx_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int j = 0; j < 4; j++) begin
            if (rnd && ($urandom_range(0, 1) == 1)) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_byte(w[31-8*j -: 8]);
        end
    endtask

    task automatic send_payload(input bit rnd);
        for (int i = 0; i < img.size(); i++) send_word(img[i], rnd);
`ifdef LOADER_CHECKSUM_EN
        send_byte(xor_img());
`endif
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wa.delete();
        wd.delete();
    endtask

    task automatic wait_end();
        int t = 0;
        rx_valid = 1'b0;
        @(negedge clk);
        while (!(done || err) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!(done || err)) begin
            tests++;
            fails++;
            $display("FAIL wait_end timeout: done=%0b err=%0b, required one set", done, err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input int n);
        check("write_count", wa.size(), n);
        for (int i = 0; i < n && i < wa.size(); i++) begin
            check($sformatf("addr[%0d]", i), wa[i], 32'(i) * 32'd4);
            check($sformatf("data[%0d]", i), wd[i], img[i]);
        end
    endtask

    typedef struct {
        logic [7:0] hdr;
        logic       exp_err;
        int         exp_writes;
    } hdr_vec_t;

    hdr_vec_t vecs[5];

    initial begin
        vecs[0] = '{8'd0,   1'b1, 0};
        vecs[1] = '{8'd33,  1'b1, 0};
        vecs[2] = '{8'd255, 1'b1, 0};
        vecs[3] = '{8'd1,   1'b0, 1};
        vecs[4] = '{8'd3,   1'b0, 3};

        // Reset values
        #12;
        check("rst_rx_ready", rx_ready, 0);
        check("rst_im_we", im_we, 0);
        check("rst_im_addr", im_addr, 32'h0);
        check("rst_im_wdata", im_wdata, 32'h0);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Bytes offered in IDLE are refused
        rx_valid = 1'b1;
        rx_data  = 8'h11;
        repeat (2) @(negedge clk);
        check("idle_rx_ready", rx_ready, 0);
        check("idle_no_write", wa.size(), 0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;

        // Two-word image, back-to-back bytes
        img.delete();
        img.push_back(32'h20080020);
        img.push_back(32'h20090037);
        pulse_start();
        send_byte(8'd2);
        send_payload(1'b0);
        wait_end();
        check_writes(2);
        check("n2_done", done, 1);
        check("n2_cpu_hold", cpu_hold, 0);
        check("n2_err", err, 0);

        // Header table
        for (int v = 0; v < 5; v++) begin
            img.delete();
            for (int k = 0; k < vecs[v].exp_writes; k++) img.push_back(gen_word(v + 16, k));
            pulse_start();
            send_byte(vecs[v].hdr);
            if (!vecs[v].exp_err) send_payload(1'b0);
            wait_end();
            rx_valid = 1'b1;
            repeat (2) @(negedge clk);
            check($sformatf("hdr%0d_err", vecs[v].hdr), err, vecs[v].exp_err);
            check($sformatf("hdr%0d_done", vecs[v].hdr), done, !vecs[v].exp_err);
            check($sformatf("hdr%0d_cpu_hold", vecs[v].hdr), cpu_hold, vecs[v].exp_err);
            check($sformatf("hdr%0d_rx_ready", vecs[v].hdr), rx_ready, 0);
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            check_writes(vecs[v].exp_writes);
        end

        // Full-depth image with gapped valid
        img.delete();
        for (int k = 0; k < 32; k++) img.push_back(gen_word(32, k));
        pulse_start();
        send_byte(8'd32);
        send_payload(1'b1);
        wait_end();
        check_writes(32);
        if (wa.size() > 0) check("n32_last_addr", wa[wa.size()-1], 32'h7C);
        check("n32_done", done, 1);

        // start wins over a byte handshaken in the same cycle
        pulse_start();
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        @(posedge clk);
        #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        check("prio_err", err, 0);
        check("prio_rx_ready", rx_ready, 1);
        @(posedge clk);
        #1;

        // Restart after 6 bytes of an N=3 load
        img.delete();
        for (int k = 0; k < 3; k++) img.push_back(gen_word(7, k));
        pulse_start();
        send_byte(8'd3);
        send_word(img[0], 1'b0);
        send_byte(img[1][31:24]);
        send_byte(img[1][23:16]);
        rx_valid = 1'b0;
        pulse_start();
        check("rs_done", done, 0);
        check("rs_rx_ready", rx_ready, 1);
        img.delete();
        img.push_back(gen_word(9, 0));
        img.push_back(gen_word(9, 1));
        send_byte(8'd2);
        send_word(img[0], 1'b0);
        rx_valid = 1'b0;
        @(negedge clk);
        check("rs_partial_done", done, 0);
        @(posedge clk);
        #1;
        send_word(img[1], 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(xor_img());
`endif
        wait_end();
        check_writes(2);
        check("rs_final_done", done, 1);

        // Asynchronous reset in the middle of LOAD
        img.delete();
        for (int k = 0; k < 4; k++) img.push_back(gen_word(4, k));
        pulse_start();
        send_byte(8'd4);
        send_word(img[0], 1'b0);
        send_byte(img[1][31:24]);
        rx_valid = 1'b0;
        wa.delete();
        wd.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_im_we", im_we, 0);
        check("mid_rst_im_addr", im_addr, 32'h0);
        check("mid_rst_im_wdata", im_wdata, 32'h0);
        check("mid_rst_cpu_hold", cpu_hold, 1);
        check("mid_rst_rx_ready", rx_ready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_writes", wa.size(), 0);
        check("post_rst_done", done, 0);
        check("post_rst_rx_ready", rx_ready, 0);
        @(posedge clk);
        #1;

`ifdef LOADER_CHECKSUM_EN
        // Checksum good then bad
        img.delete();
        img.push_back(32'h000000FF);
        pulse_start();
        send_byte(8'd1);
        send_word(img[0], 1'b0);
        send_byte(8'hFF);
        wait_end();
        check("chk_ok_done", done, 1);
        check("chk_ok_cpu_hold", cpu_hold, 0);
        pulse_start();
        send_byte(8'd1);
        send_word(img[0], 1'b0);
        send_byte(8'h00);
        wait_end();
        check("chk_bad_err", err, 1);
        check("chk_bad_done", done, 0);
        check("chk_bad_cpu_hold", cpu_hold, 1);
        check_writes(1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
